// File: rtl/seq_divider.sv
// Sequential restoring divider: unsigned DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Optional SEQ_DIV_DBZ_FAST_EN: a zero divisor skips the iterations and completes on the next edge.
module seq_divider #(
    parameter int unsigned DW = 10,
    parameter int unsigned VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] q_reg;
    logic [VW-1:0] d_reg;
    // Partial remainder is always < D between iterations, so VW bits hold it;
    // the VW+1-bit value only exists transiently as r_shift.
    logic [VW-1:0] r_reg;
    logic [CW-1:0] cnt;

    logic [VW:0]   r_shift;
    logic [VW-1:0] r_sub;
    logic          r_ge;
    logic          last_iter;

    always_comb begin
        r_shift   = {r_reg, q_reg[DW-1]};
        r_ge      = (r_shift >= {1'b0, d_reg});
        r_sub     = r_shift[VW-1:0] - d_reg;
        last_iter = (cnt == CW'(DW - 1));
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
`ifdef SEQ_DIV_DBZ_FAST_EN
                    state_nxt = (divisor == '0) ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Results and the done pulse are registered on the edge leaving DONE,
    // so they appear DW+1 edges after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg       <= dividend;
                        d_reg       <= divisor;
                        r_reg       <= '0;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    r_reg <= r_ge ? r_sub : r_shift[VW-1:0];
                    q_reg <= {q_reg[DW-2:0], r_ge};
                    cnt   <= cnt + 1'b1;
                end
                DONE: begin
                    done <= 1'b1;
                    if (d_reg == '0) begin
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_reg;
                        remainder   <= r_reg;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider: unsigned DW-bit dividend / VW-bit divisor; one quotient bit per clock.
- Inverse companion to the combinational multiplier path in the series-evaluation datapath; used for normalising results and reciprocal-style scaling.
- Self-contained FSM plus datapath; start/ready/done handshake toward the surrounding controller.

Parameters:
DW, 10, dividend and quotient width
VW, 8, divisor and remainder width (VW <= DW)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only while ready=1
dividend  input  DW  numerator; sampled on the accepted start edge
divisor  input  VW  denominator; sampled on the accepted start edge
ready  output  1  high in IDLE; block accepts start
done  output  1  one-cycle pulse; quotient/remainder valid
quotient  output  DW  result quotient, registered
remainder  output  VW  result remainder, registered
div_by_zero  output  1  registered flag; set when the latched divisor was 0

Behaviour:
- Reset, synchronous on rst=1 at a rising edge, overrides everything:
  - state=IDLE; ready=1; done=0; quotient=0; remainder=0; div_by_zero=0.
  - Internal counter, partial remainder and shift register are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch dividend into the shift register Q, divisor into D, clear partial remainder R (VW+1 bits), clear counter, clear div_by_zero, go to CALC.
  - Outputs quotient/remainder hold their previous values until DONE.
- CALC:
  - ready=0. Each cycle, one iteration:
    - R' = {R[VW-1:0], Q[DW-1]}; Q shifts left.
    - If R' >= {1'b0, D}: R = R' - D and shift in 1. Else R = R' and shift in 0.
  - Counter increments each iteration. After exactly DW iterations, go to DONE.
  - start is ignored in CALC and DONE; there is no queuing.
- DONE:
  - One cycle only. done=1; quotient=Q; remainder=R[VW-1:0]. Next edge goes to IDLE.
- Latency: start accepted at edge 0 → done high in the cycle following edge DW+1, i.e. DW+1 edges after acceptance.
  - Default DW=10: done follows 11 edges after acceptance.
  - Back-to-back: a new start can be accepted on the edge that leaves DONE+1 (IDLE). Throughput is one division per DW+2 cycles.
- Divide by zero (divisor=0 at acceptance):
  - div_by_zero=1; quotient forced to all ones; remainder forced to 0.
  - Both hold until the next accepted start or reset.
- Width rules: all arithmetic is unsigned. R is VW+1 bits so the compare never overflows. The quotient never exceeds the DW-bit range.
- Results (quotient, remainder, div_by_zero) are stable from DONE until the next accepted start. Consumers may sample at done or later.
- rst asserted mid-CALC or in DONE: the operation is discarded and no done pulse is produced. Next cycle is IDLE with reset values.
- start and rst high together: rst wins.

Optional Feature:
- Macro: SEQ_DIV_DBZ_FAST_EN.
- Defined: divisor=0 detected at acceptance → IDLE goes directly to DONE, skipping CALC. done is high in the cycle after edge 1. Forced outputs as specified above.
- Undefined: divisor=0 runs the full DW CALC iterations (latency unchanged, DW+1). Quotient/remainder/div_by_zero are still forced to the values specified above at DONE.
- The port list is identical in both builds.

Test Plan:
- After rst, start with dividend=1000, divisor=7 → done exactly 11 edges after acceptance; quotient=142, remainder=6, div_by_zero=0; ready returns 1 next cycle.
- dividend=1023/divisor=1 → quotient=1023, remainder=0. dividend=1023/divisor=255 → quotient=4, remainder=3. dividend=5/divisor=200 → quotient=0, remainder=5.
- dividend=77, divisor=0 → quotient=1023, remainder=0, div_by_zero=1.
  - With SEQ_DIV_DBZ_FAST_EN, done follows 1 edge after acceptance; without it, 11 edges.
- Accept 1000/7, then pulse start with 50/5 during CALC → ignored; result is 142 r 6. A subsequent start in IDLE with 50/5 → 10 r 0.
- Accept 900/9, assert rst on the 5th CALC cycle → no done pulse; all outputs 0, ready=1. A fresh 900/9 → 100 r 0.
- done is exactly one cycle wide for every case above. quotient/remainder hold their values for 20 idle cycles after done.
